// File: rtl/chunked_adder_sequencer.sv
// rtl/chunked_adder_sequencer.sv - multi-cycle wide adder built from a CHUNK-bit ripple-carry adder
// Optional signed-overflow output ovf is enabled by defining CHUNKED_ADDER_OVF_EN.

module ripple_carry_adder_parameter #(
    parameter int WIDTH = 8
) (
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic [WIDTH-1:0] sum,
    output logic             cout
);
    always_comb begin
        logic [WIDTH:0] c;
        c    = '0;
        sum  = '0;
        c[0] = cin;
        for (int i = 0; i < WIDTH; i++) begin
            sum[i]   = a[i] ^ b[i] ^ c[i];
            c[i + 1] = (a[i] & b[i]) | (a[i] & c[i]) | (b[i] & c[i]);
        end
        cout = c[WIDTH];
    end
endmodule

module chunked_adder_sequencer #(
    parameter int WIDTH = 32,
    parameter int CHUNK = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout
`ifdef CHUNKED_ADDER_OVF_EN
   ,output logic             ovf
`endif
);
    localparam int NCHUNK = WIDTH / CHUNK;
    localparam int IDXW   = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;
    localparam logic [IDXW-1:0] LAST_IDX = IDXW'(NCHUNK - 1);

    generate
        if ((CHUNK < 1) || (CHUNK > WIDTH) || ((WIDTH % CHUNK) != 0)) begin : g_bad_params
            $error("chunked_adder_sequencer: WIDTH must be a multiple of CHUNK, 1 <= CHUNK <= WIDTH");
        end
    endgenerate

    typedef enum logic [1:0] {IDLE, ADD, DONE} state_t;

    state_t            state;
    logic [IDXW-1:0]   idx;
    logic              carry;
    logic [WIDTH-1:0]  op_a;
    logic [WIDTH-1:0]  op_b;
    logic [CHUNK-1:0]  chunk_a;
    logic [CHUNK-1:0]  chunk_b;
    logic [CHUNK-1:0]  add_sum;
    logic              add_cout;

    assign in_ready  = (state == IDLE);
    assign out_valid = (state == DONE);
    assign chunk_a   = op_a[int'(idx) * CHUNK +: CHUNK];
    assign chunk_b   = op_b[int'(idx) * CHUNK +: CHUNK];

    ripple_carry_adder_parameter #(.WIDTH(CHUNK)) u_rca (
        .a    (chunk_a),
        .b    (chunk_b),
        .cin  (carry),
        .sum  (add_sum),
        .cout (add_cout)
    );

    // The only path for a carry between chunks is the carry register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            idx   <= '0;
            carry <= 1'b0;
            op_a  <= '0;
            op_b  <= '0;
            sum   <= '0;
            cout  <= 1'b0;
`ifdef CHUNKED_ADDER_OVF_EN
            ovf   <= 1'b0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        op_a  <= a;
                        op_b  <= b;
                        carry <= cin;
                        idx   <= '0;
                        state <= ADD;
                    end
                end
                ADD: begin
                    sum[int'(idx) * CHUNK +: CHUNK] <= add_sum;
                    carry <= add_cout;
                    if (idx == LAST_IDX) begin
                        idx   <= '0;
                        cout  <= add_cout;
`ifdef CHUNKED_ADDER_OVF_EN
                        ovf   <= (op_a[WIDTH-1] == op_b[WIDTH-1]) &&
                                 (add_sum[CHUNK-1] != op_a[WIDTH-1]);
`endif
                        state <= DONE;
                    end else begin
                        idx <= idx + IDXW'(1);
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_chunked_adder_sequencer.sv
// tb/tb_chunked_adder_sequencer.sv - directed vector bench for chunked_adder_sequencer (CHUNK=8 and CHUNK=32)

module tb_chunked_adder_sequencer;
    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] a;
    logic [31:0] b;
    logic        cin;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] sum;
    logic        cout;

    logic        iv32;
    logic        ir32;
    logic        ov32;
    logic [31:0] sum32;
    logic        cout32;
`ifdef CHUNKED_ADDER_OVF_EN
    logic        ovf;
    logic        ovf32;
`endif

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [31:0] a;
        logic [31:0] b;
        logic        cin;
        logic [31:0] exp_sum;
        logic        exp_cout;
        logic        exp_ovf;
    } vec_t;

    vec_t vecs[9];

    always #5 clk = ~clk;

    chunked_adder_sequencer #(.WIDTH(32), .CHUNK(8)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .cin       (cin),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .sum       (sum),
        .cout      (cout)
`ifdef CHUNKED_ADDER_OVF_EN
       ,.ovf       (ovf)
`endif
    );

    chunked_adder_sequencer #(.WIDTH(32), .CHUNK(32)) dut32 (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (iv32),
        .in_ready  (ir32),
        .a         (a),
        .b         (b),
        .cin       (cin),
        .out_valid (ov32),
        .out_ready (1'b1),
        .sum       (sum32),
        .cout      (cout32)
`ifdef CHUNKED_ADDER_OVF_EN
       ,.ovf       (ovf32)
`endif
    );

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    // Issue one operation and wait for the result; leaves the DUT in DONE.
    task automatic run_op(input vec_t v);
        int n;
        a        = v.a;
        b        = v.b;
        cin      = v.cin;
        in_valid = 1'b1;
        check("in_ready_at_accept", in_ready, 1'b1);
        @(posedge clk); #1;
        in_valid = 1'b0;
        a        = $urandom;
        b        = $urandom;
        cin      = 1'b1;
        n = 0;
        while (!out_valid && n < 40) begin
            @(posedge clk); #1;
            n++;
        end
        check("latency", 64'(n), 64'd4);
        check("sum", sum, v.exp_sum);
        check("cout", cout, v.exp_cout);
        check("in_ready_in_done", in_ready, 1'b0);
`ifdef CHUNKED_ADDER_OVF_EN
        check("ovf", ovf, v.exp_ovf);
`endif
    endtask

    initial begin
        vecs[0] = '{32'hFFFFFFFF, 32'h00000001, 1'b0, 32'h00000000, 1'b1, 1'b0};
        vecs[1] = '{32'h12345678, 32'h11111111, 1'b1, 32'h2345678A, 1'b0, 1'b0};
        vecs[2] = '{32'h7FFFFFFF, 32'h00000001, 1'b0, 32'h80000000, 1'b0, 1'b1};
        vecs[3] = '{32'h80000000, 32'h80000000, 1'b0, 32'h00000000, 1'b1, 1'b1};
        vecs[4] = '{32'h00000001, 32'hFFFFFFFF, 1'b0, 32'h00000000, 1'b1, 1'b0};
        vecs[5] = '{32'h00FF00FF, 32'h00010001, 1'b0, 32'h01000100, 1'b0, 1'b0};
        vecs[6] = '{32'h00000005, 32'h00000003, 1'b0, 32'h00000008, 1'b0, 1'b0};
        vecs[7] = '{32'hFFFFFFFF, 32'hFFFFFFFF, 1'b1, 32'hFFFFFFFF, 1'b1, 1'b0};
        vecs[8] = '{32'h00000000, 32'h00000000, 1'b1, 32'h00000001, 1'b0, 1'b0};

        rst_n     = 1'b0;
        in_valid  = 1'b0;
        iv32      = 1'b0;
        out_ready = 1'b1;
        a         = '0;
        b         = '0;
        cin       = 1'b0;
        #23;
        check("reset_sum", sum, 32'h0);
        check("reset_cout", cout, 1'b0);
        check("reset_out_valid", out_valid, 1'b0);
        check("reset_in_ready", in_ready, 1'b1);
        rst_n = 1'b1;
        @(posedge clk); #1;

        for (int i = 0; i < 9; i++) begin
            run_op(vecs[i]);
            @(posedge clk); #1;
            check("in_ready_after_done", in_ready, 1'b1);
            check("out_valid_after_done", out_valid, 1'b0);
        end

        // Backpressure: result held, new operands ignored
        out_ready = 1'b0;
        run_op(vecs[1]);
        for (int i = 0; i < 10; i++) begin
            in_valid = 1'b1;
            a        = 32'hDEAD0000 + 32'(i);
            b        = 32'h0000BEEF;
            cin      = 1'b0;
            @(posedge clk); #1;
            check("bp_out_valid", out_valid, 1'b1);
            check("bp_in_ready", in_ready, 1'b0);
            check("bp_sum", sum, 32'h2345678A);
            check("bp_cout", cout, 1'b0);
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        @(posedge clk); #1;
        check("bp_release_in_ready", in_ready, 1'b1);
        check("bp_release_out_valid", out_valid, 1'b0);
        run_op(vecs[5]);
        @(posedge clk); #1;

        // Reset during the second ADD cycle
        a        = 32'hFFFFFFFF;
        b        = 32'hFFFFFFFF;
        cin      = 1'b1;
        in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b0;
        #1;
        check("rst_mid_out_valid", out_valid, 1'b0);
        check("rst_mid_sum", sum, 32'h0);
        check("rst_mid_cout", cout, 1'b0);
        check("rst_mid_in_ready", in_ready, 1'b1);
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;
        check("rst_no_valid", out_valid, 1'b0);
        run_op(vecs[6]);
        @(posedge clk); #1;

        // Single-chunk build
        a    = 32'h80000000;
        b    = 32'h80000000;
        cin  = 1'b0;
        iv32 = 1'b1;
        check("c32_in_ready", ir32, 1'b1);
        @(posedge clk); #1;
        iv32 = 1'b0;
        check("c32_not_yet_valid", ov32, 1'b0);
        @(posedge clk); #1;
        check("c32_out_valid", ov32, 1'b1);
        check("c32_sum", sum32, 32'h0);
        check("c32_cout", cout32, 1'b1);
`ifdef CHUNKED_ADDER_OVF_EN
        check("c32_ovf", ovf32, 1'b1);
`endif
        @(posedge clk); #1;
        check("c32_back_idle", ir32, 1'b1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
